// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM state encoding,
// opcode values and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Opcode classifier: maps the IR opcode field onto a one-hot instruction class.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output logic            is_r,
    output logic            is_lw,
    output logic            is_sw,
    output logic            is_beq,
    output logic            is_j,
    output logic            is_addi,
    output logic            is_illegal
);

    always_comb begin
        is_r       = (op == OP_W'(OP_RTYPE));
        is_lw      = (op == OP_W'(OP_LW));
        is_sw      = (op == OP_W'(OP_SW));
        is_beq     = (op == OP_W'(OP_BEQ));
        is_j       = (op == OP_W'(OP_J));
        is_addi    = (op == OP_W'(OP_ADDI));
        is_illegal = !(is_r || is_lw || is_sw || is_beq || is_j || is_addi);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences each instruction through its states
// and drives datapath enables/selects, with optional memory-ready stalls.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int CNT_W         = 32,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               mem_rdy;
    logic               dec_r, dec_lw, dec_sw, dec_beq, dec_j, dec_addi, dec_illegal;

    mc_opcode_decode #(.OP_W(OP_W)) u_decode (
        .op         (op),
        .is_r       (dec_r),
        .is_lw      (dec_lw),
        .is_sw      (dec_sw),
        .is_beq     (dec_beq),
        .is_j       (dec_j),
        .is_addi    (dec_addi),
        .is_illegal (dec_illegal)
    );

    assign mem_rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state       = state_q;
    assign instr_count = instr_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_lw || dec_sw) state_d = S_MEMADR;
                else if (dec_r)       state_d = S_EXEC;
                else if (dec_beq)     state_d = S_BRANCH;
                else if (dec_j)       state_d = S_JUMP;
                else if (dec_addi)    state_d = S_ADDIEX;
                else                  state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (dec_lw)      state_d = S_MEMRD;
                else if (dec_sw) state_d = S_MEMWR;
                else             state_d = S_FETCH;
            end
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = dec_illegal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_rdy;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
        // Architectural side effects are suppressed for the whole reset pulse,
        // so an abandoned instruction can neither write state nor retire.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            retire     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (retire) instr_count_d = instr_count_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the stimulus side predicts per-cycle controls from the
// instruction-class state sequences; a negedge monitor pops and compares.
module tb_multicycle_controller;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    typedef struct packed {
        logic [3:0]  st;
        logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0]  alu_src_b, alu_op, pc_source;
        logic        illegal_op, retire;
        logic [31:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_ready;
    logic [5:0]  op;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, retire;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] instr_count;
    logic [3:0]  state;

    logic        rst_b, mem_ready_b;
    logic [5:0]  op_b;
    logic        pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, ir_write_b;
    logic        mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, illegal_op_b, retire_b;
    logic [1:0]  alu_src_b_b, alu_op_b, pc_source_b;
    logic [1:0]  instr_count_b;
    logic [3:0]  state_b;

    multicycle_controller #(.OP_W(6), .CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .retire(retire),
        .instr_count(instr_count), .state(state)
    );

    multicycle_controller #(.OP_W(6), .CNT_W(2), .MEM_HANDSHAKE(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .op(op_b), .mem_ready(mem_ready_b),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .iord(iord_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .pc_source(pc_source_b), .illegal_op(illegal_op_b), .retire(retire_b),
        .instr_count(instr_count_b), .state(state_b)
    );

    obs_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_cnt;

    // State visit order per class: R, lw, sw, beq, j, addi, illegal.
    int seq_tab [7][5] = '{
        '{0, 1, 6, 7, -1},
        '{0, 1, 2, 3, 4},
        '{0, 1, 2, 5, -1},
        '{0, 1, 8, -1, -1},
        '{0, 1, 9, -1, -1},
        '{0, 1, 10, 11, -1},
        '{0, 1, -1, -1, -1}
    };

    function automatic int cls(logic [5:0] o);
        case (o)
            T_R:     return 0;
            T_LW:    return 1;
            T_SW:    return 2;
            T_BEQ:   return 3;
            T_J:     return 4;
            T_ADDI:  return 5;
            default: return 6;
        endcase
    endfunction

    function automatic obs_t exp_ctl(int st, bit rdy, bit ill);
        obs_t e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            1:  begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.iord = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
            5:  begin e.mem_write = 1; e.iord = 1; e.retire = rdy; end
            6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; e.retire = 1; end
            8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                      e.pc_source = 2'b01; e.retire = 1; end
            9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.retire = 1; end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            11: begin e.reg_write = 1; e.retire = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(int st, bit rdy, bit ill);
        obs_t e;
        mem_ready = rdy;
        e = exp_ctl(st, rdy, ill);
        e.cnt = model_cnt;
        exp_q.push_back(e);
        if (e.retire) model_cnt = model_cnt + 1;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(logic [5:0] o, int fstall, int mstall, bit rnd);
        int c, st, n;
        bit rdy;
        op = o;
        c  = cls(o);
        for (int k = 0; k < 5; k++) begin
            st = seq_tab[c][k];
            if (st < 0) break;
            if (st == 0 || st == 3 || st == 5) begin
                n = 0;
                do begin
                    if (rnd) rdy = ($urandom_range(0, 2) != 0) || (n >= 8);
                    else     rdy = (n >= ((st == 0) ? fstall : mstall));
                    step(st, rdy, 1'b0);
                    n++;
                end while (!rdy);
            end else begin
                step(st, 1'($urandom_range(0, 1)), c == 6);
            end
        end
    endtask

    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '0;
            a.st = state;
            a.pc_write = pc_write;       a.pc_write_cond = pc_write_cond;
            a.iord = iord;               a.mem_read = mem_read;
            a.mem_write = mem_write;     a.ir_write = ir_write;
            a.mem_to_reg = mem_to_reg;   a.reg_dst = reg_dst;
            a.reg_write = reg_write;     a.alu_src_a = alu_src_a;
            a.alu_src_b = alu_src_b;     a.alu_op = alu_op;
            a.pc_source = pc_source;     a.illegal_op = illegal_op;
            a.retire = retire;           a.cnt = instr_count;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL trace st=%0d: got %h expected %h", e.st, a, e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] o;
        obs_t       e;
        int         sel;
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        reset = 1'b1; rst_b = 1'b1; op = T_R; mem_ready = 1'b1;
        op_b = T_R; mem_ready_b = 1'b0; model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_pc_write", 32'(pc_write), 32'd0);
        chk("reset_ir_write", 32'(ir_write), 32'd0);
        chk("reset_retire", 32'(retire), 32'd0);
        reset = 1'b0;

        run_instr(T_R, 0, 0, 0);
        chk("r_count", instr_count, 32'd1);
        run_instr(T_LW, 0, 2, 0);
        run_instr(T_SW, 0, 0, 0);
        run_instr(T_BEQ, 0, 0, 0);
        run_instr(T_J, 0, 0, 0);
        run_instr(T_ADDI, 0, 0, 0);
        chk("b2b_count", instr_count, 32'd6);
        run_instr(6'b111111, 0, 0, 0);
        chk("illegal_count", instr_count, 32'd6);

        repeat (60) begin
            sel = $urandom_range(0, 7);
            o   = (sel < 6) ? ops[sel] : 6'($urandom);
            run_instr(o, 0, 0, 1);
        end

        op = T_LW;
        step(0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0);
        mem_ready = 1'b0;
        e = exp_ctl(3, 1'b0, 1'b0);
        e.cnt = model_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_count", instr_count, 32'd0);
        chk("async_rst_reg_write", 32'(reg_write), 32'd0);
        chk("async_rst_retire", 32'(retire), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("held_rst_state", 32'(state), 32'd0);
        chk("held_rst_pc_write", 32'(pc_write), 32'd0);
        chk("held_rst_ir_write", 32'(ir_write), 32'd0);
        model_cnt = '0;
        reset = 1'b0;
        run_instr(T_R, 0, 0, 0);
        run_instr(T_SW, 1, 2, 0);
        chk("post_rst_count", instr_count, 32'd2);

        rst_b = 1'b0;
        op_b  = T_R;
        repeat (20) @(posedge clk);
        #1;
        chk("wrap_count", 32'(instr_count_b), 32'd1);
        chk("wrap_state", 32'(state_b), 32'd0);
        op_b = T_LW;
        for (int k = 0; k < 5; k++) begin
            chk("nohs_lw_state", 32'(state_b), 32'(k));
            if (k == 4) chk("nohs_lw_retire", 32'(retire_b), 32'd1);
            @(posedge clk); #1;
        end
        chk("nohs_lw_done_state", 32'(state_b), 32'd0);
        chk("nohs_lw_count", 32'(instr_count_b), 32'd2);

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
